// File: rtl/pong_state_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : pong_state_uart_tx
// Description : UART transmitter that streams a 10-byte snapshot of the Pong
//               game state. A frame_trig pulse captures the two packed state
//               words, then the frame goes out with 8N1 framing, LSB first:
//               SYNC_BYTE, word0 (LSB first), word1 (LSB first), and an XOR
//               checksum of bytes 1..8.
// Ports       :
//   clk               in   system clock
//   rst               in   asynchronous reset, active-high
//   frame_trig        in   single-cycle request to snapshot and send a frame
//   screen_mode       in   [2:0]  current screen mode
//   icon_highlighter  in   [1:0]  menu cursor
//   game_speed        in   [1:0]  speed selector
//   ball_xpos         in   [10:0] ball X
//   ball_ypos         in   [10:0] ball Y
//   left_palette_pos  in   [10:0] left paddle position
//   right_palette_pos in   [10:0] right paddle position
//   score             in   [7:0]  packed score
//   txd               out  UART serial output, idle high
//   busy              out  high while a frame is being sent
//   frame_done        out  one-cycle pulse after the last stop bit
//   trig_dropped      out  one-cycle pulse for a trigger that arrived while busy
// Revision    : 1.0 - initial release
// ============================================================================
module pong_state_uart_tx #(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_trig,
    input  logic [2:0]  screen_mode,
    input  logic [1:0]  icon_highlighter,
    input  logic [1:0]  game_speed,
    input  logic [10:0] ball_xpos,
    input  logic [10:0] ball_ypos,
    input  logic [10:0] left_palette_pos,
    input  logic [10:0] right_palette_pos,
    input  logic [7:0]  score,
    output logic        txd,
    output logic        busy,
    output logic        frame_done,
    output logic        trig_dropped
);

    localparam int             c_CW      = $clog2(CLKS_PER_BIT);
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
    localparam logic [3:0]      c_LAST_BYTE = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [c_CW-1:0] r_clk_cnt;
    logic [2:0]      r_bit_cnt;
    logic [3:0]      r_byte_idx;
    logic [31:0]     r_word0;
    logic [31:0]     r_word1;
    logic            r_txd;
    logic            r_busy;
    logic            r_frame_done;
    logic            r_trig_dropped;

    state_t          w_state_nxt;
    logic [c_CW-1:0] w_clk_cnt_nxt;
    logic [2:0]      w_bit_cnt_nxt;
    logic [3:0]      w_byte_idx_nxt;
    logic            w_txd_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            w_drop_nxt;
    logic            w_snap;
    logic            w_bit_end;
    logic [2:0]      w_bit_inc;
    logic [7:0]      w_chksum;
    logic [7:0]      w_cur_byte;

    assign w_bit_end = (r_clk_cnt == c_CNT_MAX);
    assign w_bit_inc = r_bit_cnt + 3'd1;

    // Checksum derives from the snapshot registers only, so it is stable for
    // the whole frame and cannot be disturbed by live input changes.
    assign w_chksum = r_word0[7:0]  ^ r_word0[15:8]  ^ r_word0[23:16] ^ r_word0[31:24] ^
                      r_word1[7:0]  ^ r_word1[15:8]  ^ r_word1[23:16] ^ r_word1[31:24];

    always_comb begin
        w_cur_byte = SYNC_BYTE;
        case (r_byte_idx)
            4'd1:    w_cur_byte = r_word0[7:0];
            4'd2:    w_cur_byte = r_word0[15:8];
            4'd3:    w_cur_byte = r_word0[23:16];
            4'd4:    w_cur_byte = r_word0[31:24];
            4'd5:    w_cur_byte = r_word1[7:0];
            4'd6:    w_cur_byte = r_word1[15:8];
            4'd7:    w_cur_byte = r_word1[23:16];
            4'd8:    w_cur_byte = r_word1[31:24];
            4'd9:    w_cur_byte = w_chksum;
            default: w_cur_byte = SYNC_BYTE;
        endcase
    end

    // Next-state logic. txd is registered: each transition loads the level of
    // the bit that starts on that edge, so the line changes one cycle after
    // the decision is made.
    always_comb begin
        w_state_nxt    = r_state;
        w_clk_cnt_nxt  = r_clk_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_byte_idx_nxt = r_byte_idx;
        w_txd_nxt      = r_txd;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_drop_nxt     = frame_trig & r_busy;
        w_snap         = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_txd_nxt = 1'b1;
                if (frame_trig) begin
                    w_state_nxt    = S_START;
                    w_txd_nxt      = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_snap         = 1'b1;
                    w_clk_cnt_nxt  = '0;
                    w_bit_cnt_nxt  = '0;
                    w_byte_idx_nxt = '0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = S_DATA;
                    w_clk_cnt_nxt = '0;
                    w_bit_cnt_nxt = '0;
                    w_txd_nxt     = w_cur_byte[0];
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_CNT_ONE;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_cnt_nxt = w_bit_inc;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_txd_nxt   = 1'b1;
                    end else begin
                        w_txd_nxt = w_cur_byte[w_bit_inc];
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_CNT_ONE;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    if (r_byte_idx == c_LAST_BYTE) begin
                        w_state_nxt    = S_IDLE;
                        w_busy_nxt     = 1'b0;
                        w_done_nxt     = 1'b1;
                        w_byte_idx_nxt = '0;
                    end else begin
                        // Next start bit follows the stop bit with no gap.
                        w_state_nxt    = S_START;
                        w_txd_nxt      = 1'b0;
                        w_byte_idx_nxt = r_byte_idx + 4'd1;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_txd_nxt   = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_clk_cnt      <= '0;
            r_bit_cnt      <= '0;
            r_byte_idx     <= '0;
            r_txd          <= 1'b1;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
            r_trig_dropped <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_clk_cnt      <= w_clk_cnt_nxt;
            r_bit_cnt      <= w_bit_cnt_nxt;
            r_byte_idx     <= w_byte_idx_nxt;
            r_txd          <= w_txd_nxt;
            r_busy         <= w_busy_nxt;
            r_frame_done   <= w_done_nxt;
            r_trig_dropped <= w_drop_nxt;
        end
    end

    // Snapshot of the state words, same packing the GPIO drives to video.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word0 <= '0;
            r_word1 <= '0;
        end else if (w_snap) begin
            r_word0 <= {screen_mode, icon_highlighter, game_speed, 3'b000,
                        ball_ypos, ball_xpos};
            r_word1 <= {2'b00, score, left_palette_pos, right_palette_pos};
        end
    end

    assign txd          = r_txd;
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;
    assign trig_dropped = r_trig_dropped;

endmodule
`default_nettype wire

// File: tb/tb_pong_state_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_state_uart_tx
// Description : Self-checking bench for pong_state_uart_tx. Table vectors and
//               random frames are compared cycle by cycle against an
//               expected serial waveform built from a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_state_uart_tx;

    localparam int CPB = 4;
    localparam int N   = 100 * CPB;

    typedef struct {
        logic [2:0]  mode;
        logic [1:0]  icon;
        logic [1:0]  speed;
        logic [10:0] x;
        logic [10:0] y;
        logic [10:0] l;
        logic [10:0] r;
        logic [7:0]  score;
        logic [79:0] exp;
        bit          use_model;
        int          drop_at;
        int          hold;
        bit          chain;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_trig;
    logic [2:0]  screen_mode;
    logic [1:0]  icon_highlighter;
    logic [1:0]  game_speed;
    logic [10:0] ball_xpos;
    logic [10:0] ball_ypos;
    logic [10:0] left_palette_pos;
    logic [10:0] right_palette_pos;
    logic [7:0]  score;
    logic        txd;
    logic        busy;
    logic        frame_done;
    logic        trig_dropped;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t next_v;

    always #5 clk = ~clk;

    pong_state_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .frame_trig        (frame_trig),
        .screen_mode       (screen_mode),
        .icon_highlighter  (icon_highlighter),
        .game_speed        (game_speed),
        .ball_xpos         (ball_xpos),
        .ball_ypos         (ball_ypos),
        .left_palette_pos  (left_palette_pos),
        .right_palette_pos (right_palette_pos),
        .score             (score),
        .txd               (txd),
        .busy              (busy),
        .frame_done        (frame_done),
        .trig_dropped      (trig_dropped)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] mode, input logic [1:0] icon,
                                input logic [1:0] speed, input logic [10:0] x,
                                input logic [10:0] y, input logic [10:0] l,
                                input logic [10:0] r, input logic [7:0] sc,
                                input logic [79:0] exp, input bit use_model,
                                input int drop_at, input int hold, input bit chain);
        vec_t v;
        v.mode = mode; v.icon = icon; v.speed = speed;
        v.x = x; v.y = y; v.l = l; v.r = r; v.score = sc;
        v.exp = exp; v.use_model = use_model;
        v.drop_at = drop_at; v.hold = hold; v.chain = chain;
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        return mk(3'($urandom), 2'($urandom), 2'($urandom), 11'($urandom),
                  11'($urandom), 11'($urandom), 11'($urandom), 8'($urandom),
                  80'h0, 1'b1, -1, 0, 1'b0);
    endfunction

    // Frame model: fields weighted into two integers, then split into bytes.
    function automatic logic [79:0] model(input vec_t v);
        longint     w0;
        longint     w1;
        logic [7:0] b [10];
        logic [7:0] c;
        logic [79:0] f;
        w0 = longint'(v.x) + longint'(v.y) * 2048 + longint'(v.speed) * (longint'(1) << 25)
           + longint'(v.icon) * (longint'(1) << 27) + longint'(v.mode) * (longint'(1) << 29);
        w1 = longint'(v.r) + longint'(v.l) * 2048 + longint'(v.score) * (longint'(1) << 22);
        b[0] = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            b[1 + k] = 8'((w0 / (longint'(1) << (8 * k))) % 256);
            b[5 + k] = 8'((w1 / (longint'(1) << (8 * k))) % 256);
        end
        c = 8'h00;
        for (int k = 1; k <= 8; k++) c = c ^ b[k];
        b[9] = c;
        for (int k = 0; k < 10; k++) f[8 * k +: 8] = b[k];
        return f;
    endfunction

    task automatic drive_inputs(input vec_t v);
        screen_mode       = v.mode;
        icon_highlighter  = v.icon;
        game_speed        = v.speed;
        ball_xpos         = v.x;
        ball_ypos         = v.y;
        left_palette_pos  = v.l;
        right_palette_pos = v.r;
        score             = v.score;
    endtask

    // Called on a negedge; leaves the bench at sample 0 (first cycle after trig).
    task automatic start(input vec_t v);
        drive_inputs(v);
        frame_trig = 1'b1;
        @(negedge clk);
    endtask

    task automatic capture(input string tag, input vec_t v, input logic [79:0] exp);
        logic [N:0] tx;
        logic [N:0] bs;
        logic [N:0] dn;
        logic [7:0] eb;
        logic [7:0] d;
        logic       ebit;
        int         drops;
        int         wave_err;
        int         bcnt;
        int         dcnt;
        int         b;
        int         j;
        drops = 0;
        for (int i = 0; i <= N; i++) begin
            tx[i] = txd;
            bs[i] = busy;
            dn[i] = frame_done;
            if (trig_dropped) drops++;
            if (i == v.hold) frame_trig = 1'b0;
            if (i == v.drop_at) begin
                frame_trig = 1'b1;
                drive_inputs(rnd_vec());
            end else if (v.drop_at >= 0 && i == v.drop_at + 1) begin
                frame_trig = 1'b0;
            end
            if (v.chain && i >= N - 1) begin
                frame_trig = 1'b1;
                if (i == N) drive_inputs(next_v);
            end
            if (i < N) @(negedge clk);
        end
        if (v.chain) begin
            @(negedge clk);
            frame_trig = 1'b0;
        end

        wave_err = 0;
        for (int i = 0; i < N; i++) begin
            b  = i / (10 * CPB);
            j  = (i % (10 * CPB)) / CPB;
            eb = exp[8 * b +: 8];
            if (j == 0)      ebit = 1'b0;
            else if (j <= 8) ebit = eb[j - 1];
            else             ebit = 1'b1;
            if (tx[i] !== ebit) wave_err++;
        end
        chk({tag, " wave_errs"}, wave_err, 0);
        chk({tag, " txd_first"}, 32'(tx[0]), 0);
        for (int k = 0; k < 10; k++) begin
            for (int m = 0; m < 8; m++) d[m] = tx[k * 10 * CPB + (m + 1) * CPB + CPB / 2];
            eb = exp[8 * k +: 8];
            chk($sformatf("%s byte%0d", tag, k), 32'(d), 32'(eb));
        end
        bcnt = 0;
        dcnt = 0;
        for (int i = 0; i < N; i++) if (bs[i] === 1'b1) bcnt++;
        for (int i = 0; i <= N; i++) if (dn[i] === 1'b1) dcnt++;
        chk({tag, " busy_cycles"}, bcnt, N);
        chk({tag, " busy_end"}, 32'(bs[N]), 0);
        chk({tag, " done_count"}, dcnt, 1);
        chk({tag, " done_at_end"}, 32'(dn[N]), 1);
        chk({tag, " drops"}, drops, v.hold + (v.drop_at >= 0 ? 1 : 0) + (v.chain ? 1 : 0));
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        start(v);
        capture(tag, v, v.use_model ? model(v) : v.exp);
    endtask

    initial begin
        vec_t tbl [5];
        vec_t va;
        vec_t vb;
        vec_t vr;

        tbl[0] = mk(0, 0, 0, 11'h000, 0, 0, 0, 8'h00,
                    {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5},
                    1'b0, -1, 0, 1'b0);
        tbl[1] = mk(0, 0, 0, 11'h0FF, 0, 0, 0, 8'h00,
                    {8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hA5},
                    1'b0, -1, 0, 1'b0);
        tbl[2] = mk(0, 0, 0, 11'h000, 0, 0, 0, 8'h5A,
                    {8'h96, 8'h16, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5},
                    1'b0, -1, 0, 1'b0);
        tbl[3] = mk(3'd5, 2'd2, 2'd1, 11'h3C1, 11'h27E, 11'h155, 11'h6AA, 8'hC3,
                    80'h0, 1'b1, 150, 0, 1'b0);
        tbl[4] = mk(3'd7, 2'd3, 2'd3, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 8'hFF,
                    80'h0, 1'b1, -1, 3, 1'b0);

        rst = 1'b1;
        frame_trig = 1'b0;
        drive_inputs(tbl[0]);
        repeat (3) @(negedge clk);
        chk("reset txd", 32'(txd), 1);
        chk("reset busy", 32'(busy), 0);
        chk("reset frame_done", 32'(frame_done), 0);
        chk("reset trig_dropped", 32'(trig_dropped), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 5; t++) run_vec($sformatf("tbl%0d", t), tbl[t]);

        // Reset during byte 4, then a fresh frame.
        vr = rnd_vec();
        start(vr);
        frame_trig = 1'b0;
        repeat (4 * 10 * CPB + 5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset txd", 32'(txd), 1);
        chk("midreset busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_reset txd", 32'(txd), 1);
        chk("post_reset busy", 32'(busy), 0);
        vr = rnd_vec();
        run_vec("after_reset", vr);

        // Trigger in the last busy cycle is dropped; one cycle later it starts.
        va = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 80'h0, 1'b1, -1, 0, 1'b1);
        vb = rnd_vec();
        next_v = vb;
        start(va);
        capture("chainA", va, model(va));
        capture("chainB", vb, model(vb));

        for (int t = 0; t < 6; t++) begin
            vr = rnd_vec();
            if ($urandom_range(0, 1) == 1) vr.drop_at = int'($urandom_range(5, N - 10));
            run_vec($sformatf("rand%0d", t), vr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

endmodule
`default_nettype wire
